// File: rtl/iir_inv_section2.sv
// iir_inv_section2
// Second-order inverse (pole-cancelling FIR) section:
//   y[n] = x[n] - MA1*x[n-1] - MA2*x[n-2]
// One 11x12 signed multiplier is time-shared across two cycles.
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   x carries a sample
//   in_ready   out  block accepts a sample this cycle (registered, IDLE only)
//   x          in   signed Q1.10 input sample
//   out_valid  out  y carries a result (registered)
//   out_ready  in   downstream accepts y this cycle
//   y          out  signed Q1.10 output sample (registered)
module iir_inv_section2 #(
    parameter logic signed [11:0] MA1 = 12'sh608,  // Q2.10, +1.5078
    parameter logic signed [11:0] MA2 = 12'shC8F   // Q2.10, -0.8604
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [10:0] x,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [10:0] y
);

    typedef enum logic [1:0] {IDLE, M1, M2, OUT} state_t;

    state_t             state_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic signed [10:0] y_q;
    logic signed [10:0] xl_q;   // sample latched at accept
    logic signed [10:0] x1_q;   // x[n-1]
    logic signed [10:0] x2_q;   // x[n-2]
    // Q5.20: |x<<10| + |2 products| stays below 2^23, so 25 bits never overflow
    logic signed [24:0] acc_q;

    logic signed [10:0] mul_a;
    logic signed [11:0] mul_b;
    logic signed [22:0] prod;      // Q3.20
    logic signed [24:0] acc_load;  // x in Q5.20
    logic signed [24:0] diff;
    logic signed [24:0] rnd;
    logic signed [10:0] sat;

    // Shared multiplier: M2 uses x[n-2]/MA2, otherwise x[n-1]/MA1
    always_comb begin
        mul_a = x1_q;
        mul_b = MA1;
        if (state_q == M2) begin
            mul_a = x2_q;
            mul_b = MA2;
        end
        prod = 23'(mul_a) * 23'(mul_b);
    end

    always_comb begin
        acc_load = {{4{x[10]}}, x, 10'b0};
        diff     = acc_q - 25'(prod);
        // Round half up, then drop the 10 extra fraction bits
        rnd      = (diff + 25'sd512) >>> 10;
        sat      = rnd[10:0];
        if (rnd > 25'sd1023)
            sat = 11'sd1023;
        else if (rnd < -25'sd1024)
            sat = -11'sd1024;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            xl_q        <= '0;
            x1_q        <= '0;
            x2_q        <= '0;
            acc_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // in_ready comes up one edge after reset release
                    in_ready_q <= 1'b1;
                    if (in_ready_q && in_valid) begin
                        xl_q       <= x;
                        acc_q      <= acc_load;
                        in_ready_q <= 1'b0;
                        state_q    <= M1;
                    end
                end
                M1: begin
                    acc_q   <= diff;
                    state_q <= M2;
                end
                M2: begin
                    // History moves only here, so a stalled sample cannot corrupt it
                    y_q         <= sat;
                    x2_q        <= x1_q;
                    x1_q        <= xl_q;
                    out_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y         = y_q;

endmodule

// File: tb/tb_iir_inv_section2.sv
// Directed testbench for iir_inv_section2.
module tb_iir_inv_section2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [10:0] x = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [10:0] y;

    int n_cmp = 0;
    int n_err = 0;

    iir_inv_section2 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        x         = '0;
        rst_n     = 1'b0;
        #13;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Push one sample through with out_ready=1; returns y, or to=1 on timeout.
    task automatic run_sample(input logic signed [10:0] xv,
                              output logic signed [10:0] yv, output bit to);
        int cnt;
        to = 1'b0;
        yv = '0;
        cnt = 0;
        @(negedge clk);
        while (!in_ready && cnt < 20) begin @(negedge clk); cnt++; end
        if (!in_ready) begin to = 1'b1; return; end
        in_valid = 1'b1;
        x        = xv;
        @(posedge clk);
        #1 in_valid = 1'b0;
        cnt = 0;
        @(negedge clk);
        while (!out_valid && cnt < 20) begin @(negedge clk); cnt++; end
        if (!out_valid) begin to = 1'b1; return; end
        yv = y;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic signed [10:0] yv;
        bit to;
        apply_reset();
        run_sample(11'sd512, yv, to);
        // park a result in OUT, then reset asynchronously between edges
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; x = 11'sd300;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++;
        if (y !== 11'sd0) begin n_err++; $display("FAIL reset_y: got %0d want 0", $signed(y)); end
        n_cmp++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready_pre_edge: got %b want 0", in_ready); end
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready_post_edge: got %b want 1", in_ready); end
    endtask

    task automatic test_impulse(input string tag);
        int xs[4] = '{512, 0, 0, 0};
        int ex[4] = '{512, -772, 441, 0};
        logic signed [10:0] yv;
        bit to;
        for (int i = 0; i < 4; i++) begin
            run_sample(11'(xs[i]), yv, to);
            n_cmp++;
            if (to || yv !== 11'(ex[i])) begin
                n_err++;
                $display("FAIL %s[%0d]: got %0d (timeout=%0d) want %0d", tag, i, $signed(yv), to, ex[i]);
            end
        end
    endtask

    task automatic test_step();
        int ex[3] = '{1023, -519, 361};
        logic signed [10:0] yv;
        bit to;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            run_sample(11'sd1023, yv, to);
            n_cmp++;
            if (to || yv !== 11'(ex[i])) begin
                n_err++;
                $display("FAIL step[%0d]: got %0d (timeout=%0d) want %0d", i, $signed(yv), to, ex[i]);
            end
        end
    endtask

    task automatic test_saturation();
        int xs[3] = '{-1024, 1023, -1024};
        int ex[3] = '{-1024, 1023, -1024};
        logic signed [10:0] yv;
        bit to;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            run_sample(11'(xs[i]), yv, to);
            n_cmp++;
            if (to || yv !== 11'(ex[i])) begin
                n_err++;
                $display("FAIL sat[%0d]: got %0d (timeout=%0d) want %0d", i, $signed(yv), to, ex[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int xs[4] = '{512, 0, 0, 0};
        int ex[4] = '{512, -772, 441, 0};
        logic signed [10:0] y0;
        int cnt;
        apply_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cnt = 0;
            @(negedge clk);
            while (!in_ready && cnt < 20) begin @(negedge clk); cnt++; end
            in_valid = 1'b1; x = 11'(xs[i]);
            @(posedge clk); #1 in_valid = 1'b0;
            cnt = 0;
            @(negedge clk);
            while (!out_valid && cnt < 20) begin @(negedge clk); cnt++; end
            y0 = y;
            n_cmp++;
            if (!out_valid || y0 !== 11'(ex[i])) begin
                n_err++;
                $display("FAIL bp_y[%0d]: got %0d valid=%b want %0d", i, $signed(y0), out_valid, ex[i]);
            end
            // junk sample offered while busy must be ignored
            in_valid = 1'b1; x = -11'sd1024;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                n_cmp++;
                if (out_valid !== 1'b1 || y !== y0 || in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL bp_hold[%0d.%0d]: valid=%b y=%0d ready=%b want 1/%0d/0",
                             i, k, out_valid, $signed(y), in_ready, $signed(y0));
                end
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            n_cmp++;
            if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drop[%0d]: got %b want 0", i, out_valid); end
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset_mid_op();
        logic signed [10:0] yv;
        bit to;
        apply_reset();
        run_sample(11'sd300, yv, to);   // build non-zero history
        @(negedge clk);
        in_valid = 1'b1; x = 11'sd400;
        @(posedge clk); #1 in_valid = 1'b0;   // E0: accept
        @(posedge clk);                        // E1: now in M2
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid_after: got %b want 0", out_valid); end
        test_impulse("midrst_imp");
    endtask

    task automatic test_timing();
        int  last_acc = -1;
        int  n_acc = 0;
        bit  prev_ov = 1'b0;
        apply_reset();
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 48; cyc++) begin
            @(negedge clk);
            if (out_valid && !prev_ov) begin
                n_cmp++;
                if (cyc - last_acc != 3) begin
                    n_err++;
                    $display("FAIL timing_latency: got %0d edges want 3", cyc - last_acc);
                end
            end
            prev_ov = out_valid;
            in_valid = ~in_valid;
            x = 11'(cyc * 17);
            if (in_valid && in_ready) begin
                if (last_acc >= 0) begin
                    n_cmp++;
                    if (cyc - last_acc != 4) begin
                        n_err++;
                        $display("FAIL timing_interval: got %0d cycles want 4", cyc - last_acc);
                    end
                end
                last_acc = cyc;
                n_acc++;
            end
        end
        in_valid = 1'b0;
        n_cmp++;
        if (n_acc < 8) begin n_err++; $display("FAIL timing_accepts: got %0d want >=8", n_acc); end
    endtask

    initial begin
        test_reset();
        apply_reset();
        test_impulse("impulse");
        test_step();
        test_saturation();
        test_backpressure();
        test_reset_mid_op();
        test_timing();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
